// File: rtl/booth_pkg.sv
// Shared types for the sequential Booth multiplier: controller states and
// the radix-2 Booth recoding of the {multiplier LSB, extra bit} pair.
package booth_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        OP_NOP = 2'd0,
        OP_ADD = 2'd1,
        OP_SUB = 2'd2
    } booth_op_t;

    localparam logic [1:0] PAIR_ADD = 2'b01;
    localparam logic [1:0] PAIR_SUB = 2'b10;

    function automatic booth_op_t decode_op(input logic [1:0] pair);
        case (pair)
            PAIR_ADD: return OP_ADD;
            PAIR_SUB: return OP_SUB;
            default:  return OP_NOP;
        endcase
    endfunction

endpackage

// File: rtl/booth_step.sv
// One radix-2 Booth iteration: optional add/sub of the multiplicand into the
// accumulator, then an arithmetic right shift of {acc, mreg, q_res}.
module booth_step
    import booth_pkg::*;
#(
    parameter int width = 6
) (
    input  logic [width:0]   acc,
    input  logic [width-1:0] mreg,
    input  logic             q_res,
    input  logic [width-1:0] mcand,
    output logic [width:0]   acc_nxt,
    output logic [width-1:0] mreg_nxt,
    output logic             q_nxt
);

    logic [width:0] mcand_ext;
    logic [width:0] sum;

    // The extra accumulator bit lets -2^(width-1) be subtracted without overflow.
    assign mcand_ext = {mcand[width-1], mcand};

    // NOTE: every variable written in always_comb gets a default first so no latch is inferred.
    always_comb begin
        sum = acc;
        case (decode_op({mreg[0], q_res}))
            OP_ADD:  sum = acc + mcand_ext;
            OP_SUB:  sum = acc - mcand_ext;
            default: sum = acc;
        endcase
    end

    assign acc_nxt  = {sum[width], sum[width:1]};
    assign mreg_nxt = {sum[0], mreg[width-1:1]};
    assign q_nxt    = mreg[0];

endmodule

// File: rtl/booth_seq_arbiter.sv
// Round-robin front end and controller for a shared sequential Booth
// multiplier; one Booth step per clock, product returned with requester id.
module booth_seq_arbiter
    import booth_pkg::*;
#(
    parameter int width = 6,
    parameter int NREQ  = 4,
    parameter int IDW   = $clog2(NREQ)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NREQ-1:0]         req_valid,
    output logic [NREQ-1:0]         req_ready,
    input  logic [NREQ*width-1:0]   req_in1,
    input  logic [NREQ*width-1:0]   req_in2,
    output logic                    resp_valid,
    input  logic                    resp_ready,
    output logic [IDW-1:0]          resp_id,
    output logic [2*width-1:0]      out,
    output logic                    busy
);

    localparam int CW = $clog2(width + 1);

    state_t           state, state_nxt;
    logic [IDW-1:0]   rr_ptr;
    logic [IDW-1:0]   id_q;
    logic [width:0]   acc;
    logic [width-1:0] mreg;
    logic             q_res;
    logic [width-1:0] mcand;
    logic [CW-1:0]    count;

    logic             grant_found;
    logic [IDW-1:0]   grant_idx;
    logic [IDW:0]     scan;

    logic [width:0]   acc_nxt;
    logic [width-1:0] mreg_nxt;
    logic             q_nxt;

    booth_step #(.width(width)) u_step (
        .acc      (acc),
        .mreg     (mreg),
        .q_res    (q_res),
        .mcand    (mcand),
        .acc_nxt  (acc_nxt),
        .mreg_nxt (mreg_nxt),
        .q_nxt    (q_nxt)
    );

    // First valid requester at or after rr_ptr, wrapping at NREQ.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        scan        = '0;
        for (int i = 0; i < NREQ; i++) begin
            scan = {1'b0, rr_ptr} + (IDW+1)'(i);
            if (scan >= (IDW+1)'(NREQ))
                scan = scan - (IDW+1)'(NREQ);
            if (!grant_found && req_valid[scan[IDW-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = scan[IDW-1:0];
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (grant_found) state_nxt = RUN;
            RUN:     if (count == CW'(1)) state_nxt = DONE;
            DONE:    if (resp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        req_ready  = '0;
        resp_valid = (state == DONE);
        busy       = (state != IDLE);
        out        = '0;
        if (state == IDLE && grant_found)
            req_ready[grant_idx] = 1'b1;
        if (state == DONE)
            out = {acc[width-1:0], mreg};
    end

    assign resp_id = id_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= '0;
            id_q   <= '0;
            acc    <= '0;
            mreg   <= '0;
            q_res  <= 1'b0;
            mcand  <= '0;
            count  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_found) begin
                        mcand  <= req_in1[grant_idx*width +: width];
                        mreg   <= req_in2[grant_idx*width +: width];
                        acc    <= '0;
                        q_res  <= 1'b0;
                        count  <= CW'(width);
                        id_q   <= grant_idx;
                        rr_ptr <= (grant_idx == IDW'(NREQ-1)) ? '0 : grant_idx + 1'b1;
                    end
                end
                RUN: begin
                    acc   <= acc_nxt;
                    mreg  <= mreg_nxt;
                    q_res <= q_nxt;
                    count <= count - 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_booth_seq_arbiter.sv
// Self-checking bench for booth_seq_arbiter: directed vector table, multi-cycle
// corner sequences, and randomized traffic against a product/round-robin model.
module tb_booth_seq_arbiter;

    localparam int W    = 6;
    localparam int NREQ = 4;
    localparam int IDW  = 2;
    localparam int LAT  = W + 1;

    logic                  clk;
    logic                  rst_n;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*W-1:0]     req_in1;
    logic [NREQ*W-1:0]     req_in2;
    logic                  resp_valid;
    logic                  resp_ready;
    logic [IDW-1:0]        resp_id;
    logic [2*W-1:0]        out;
    logic                  busy;

    booth_seq_arbiter #(.width(W), .NREQ(NREQ), .IDW(IDW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_in1    (req_in1),
        .req_in2    (req_in2),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_id    (resp_id),
        .out        (out),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] a_op [NREQ];
    logic [W-1:0] b_op [NREQ];
    int           rr_m;

    typedef struct {
        int           id;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [2*W-1:0] exp;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive_ops();
        for (int k = 0; k < NREQ; k++) begin
            req_in1[k*W +: W] = a_op[k];
            req_in2[k*W +: W] = b_op[k];
        end
    endtask

    // Round-robin model: first set bit of mask at or after rr_m.
    function automatic int pick(input logic [NREQ-1:0] mask);
        for (int i = 0; i < NREQ; i++) begin
            if (mask[(rr_m + i) % NREQ]) return (rr_m + i) % NREQ;
        end
        return -1;
    endfunction

    function automatic logic [2*W-1:0] model_prod(input int g);
        int          pa, pb;
        logic [31:0] p;
        pa = $signed(a_op[g]);
        pb = $signed(b_op[g]);
        p  = pa * pb;
        return p[2*W-1:0];
    endfunction

    // Count cycles from the grant edge until resp_valid, watching for stray grants.
    task automatic wait_resp(output int lat, output int leak);
        lat  = 0;
        leak = 0;
        while (lat < 40) begin
            @(negedge clk);
            lat++;
            if (resp_valid) break;
            if (req_ready != '0 || !busy) leak++;
        end
    endtask

    task automatic finish_txn(input int g, input logic [2*W-1:0] exp_out, input string tag);
        int lat, leak;
        wait_resp(lat, leak);
        check({tag, "_latency"}, 32'(lat), 32'(LAT));
        check({tag, "_no_ready_in_run"}, 32'(leak), 32'd0);
        check({tag, "_out"}, 32'(out), 32'(exp_out));
        check({tag, "_resp_id"}, 32'(resp_id), 32'(g));
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        resp_ready = 1'b0;
        check({tag, "_resp_cleared"}, 32'(resp_valid), 32'd0);
        rr_m = (g + 1) % NREQ;
    endtask

    task automatic run_txn(input logic [NREQ-1:0] mask, input bit hold,
                           input logic [2*W-1:0] exp_out, input string tag);
        int g;
        g = pick(mask);
        @(negedge clk);
        drive_ops();
        req_valid = mask;
        #2;
        check({tag, "_grant"}, 32'(req_ready), 32'(1 << g));
        @(posedge clk);
        #1;
        if (!hold) req_valid = '0;
        finish_txn(g, exp_out, tag);
    endtask

    vec_t vecs [9];

    initial begin
        int g1, g2;
        logic [2*W-1:0] held_out;
        logic [IDW-1:0] held_id;
        int lat, leak;

        vecs[0] = '{0, 6'h03, 6'h3B, 12'hFF1};
        vecs[1] = '{1, 6'h20, 6'h20, 12'h400};
        vecs[2] = '{2, 6'h20, 6'h1F, 12'hC20};
        vecs[3] = '{3, 6'h00, 6'h2F, 12'h000};
        vecs[4] = '{0, 6'h3F, 6'h3F, 12'h001};
        vecs[5] = '{1, 6'h20, 6'h01, 12'hFE0};
        vecs[6] = '{2, 6'h1F, 6'h1F, 12'h3C1};
        vecs[7] = '{3, 6'h01, 6'h20, 12'hFE0};
        vecs[8] = '{1, 6'h07, 6'h06, 12'h02A};

        rst_n      = 1'b0;
        req_valid  = '0;
        resp_ready = 1'b0;
        req_in1    = '0;
        req_in2    = '0;
        rr_m       = 0;
        for (int k = 0; k < NREQ; k++) begin
            a_op[k] = W'(k + 1);
            b_op[k] = W'(k + 10);
        end

        #12;
        check("reset_out", 32'(out), 32'd0);
        check("reset_resp_valid", 32'(resp_valid), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_resp_id", 32'(resp_id), 32'd0);
        check("reset_req_ready", 32'(req_ready), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // All requesters held valid: grants must rotate 0,1,2,3,0.
        for (int i = 0; i < 5; i++) begin
            check($sformatf("fair%0d_order", i), 32'(pick(4'hF)), 32'(i % NREQ));
            run_txn(4'hF, 1'b1, model_prod(pick(4'hF)), $sformatf("fair%0d", i));
        end
        req_valid = '0;

        for (int i = 0; i < 9; i++) begin
            a_op[vecs[i].id] = vecs[i].a;
            b_op[vecs[i].id] = vecs[i].b;
            run_txn(4'(1 << vecs[i].id), 1'b0, vecs[i].exp, $sformatf("vec%0d", i));
        end

        // Backpressure in DONE while another requester waits.
        a_op[1] = 6'h05; b_op[1] = 6'h3D;
        a_op[2] = 6'h3A; b_op[2] = 6'h09;
        @(negedge clk);
        drive_ops();
        req_valid = 4'b0010;
        g1 = pick(4'b0010);
        #2;
        check("bp_grant1", 32'(req_ready), 32'(1 << g1));
        @(posedge clk);
        #1;
        req_valid = 4'b0100;
        wait_resp(lat, leak);
        check("bp_latency", 32'(lat), 32'(LAT));
        check("bp_no_ready_in_run", 32'(leak), 32'd0);
        check("bp_out", 32'(out), 32'(model_prod(g1)));
        held_out = out;
        held_id  = resp_id;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check($sformatf("bp_hold%0d_out", i), 32'(out), 32'(held_out));
            check($sformatf("bp_hold%0d_id", i), 32'(resp_id), 32'(held_id));
            check($sformatf("bp_hold%0d_ready", i), 32'(req_ready), 32'd0);
            check($sformatf("bp_hold%0d_valid", i), 32'(resp_valid), 32'd1);
        end
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        resp_ready = 1'b0;
        rr_m = (g1 + 1) % NREQ;
        g2 = pick(4'b0100);
        check("bp_idle_after_ack", 32'(resp_valid), 32'd0);
        check("bp_next_grant", 32'(req_ready), 32'(1 << g2));
        @(posedge clk);
        #1;
        req_valid = '0;
        check("bp_next_busy", 32'(busy), 32'd1);
        finish_txn(g2, model_prod(g2), "bp2");

        // Randomized traffic against the model.
        for (int i = 0; i < 30; i++) begin
            logic [NREQ-1:0] mask;
            int g;
            mask = NREQ'($urandom_range(1, (1 << NREQ) - 1));
            for (int k = 0; k < NREQ; k++) begin
                a_op[k] = W'($urandom);
                b_op[k] = W'($urandom);
            end
            g = pick(mask);
            run_txn(mask, 1'b0, model_prod(g), $sformatf("rnd%0d", i));
        end

        // Reset three steps into RUN aborts the operation.
        a_op[3] = 6'h15; b_op[3] = 6'h2B;
        @(negedge clk);
        drive_ops();
        req_valid = 4'b1000;
        @(posedge clk);
        #1;
        req_valid = '0;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_out", 32'(out), 32'd0);
        check("midrst_resp_valid", 32'(resp_valid), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_resp_id", 32'(resp_id), 32'd0);
        check("midrst_req_ready", 32'(req_ready), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        rr_m  = 0;
        a_op[0] = 6'h07; b_op[0] = 6'h06;
        run_txn(4'b0001, 1'b0, 12'h02A, "post_reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/booth_seq_arbiter.md
Name: booth_seq_arbiter

Overview:
- Shared sequential radix-2 Booth signed multiplier.
- Serves NREQ requesters through round-robin arbitration with valid/ready handshakes.
- Executes one Booth add/sub-and-shift step per clock instead of an unrolled combinational loop.
- Sits between requesting datapath blocks and one shared multiply resource; returns the product tagged with the requester index.

Parameters:
- width, 6, operand width in bits; product is 2*width.
- NREQ, 4, number of requesters (2..8).
- IDW, $clog2(NREQ), requester-index width.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  NREQ  per-requester operand valid.
- req_ready  output  NREQ  per-requester grant/accept; at most one bit high.
- req_in1  input  NREQ*width  packed multiplicands, signed; requester k at [k*width +: width].
- req_in2  input  NREQ*width  packed multipliers, signed; same packing.
- resp_valid  output  1  product valid.
- resp_ready  input  1  consumer accepts product.
- resp_id  output  IDW  index of the requester owning the product.
- out  output  2*width  signed product in1*in2.
- busy  output  1  high whenever state is not IDLE.

Behaviour:
- Reset (async, rst_n low):
  - State IDLE, rr pointer 0.
  - accumulator (width+1 bits, sign-extended to absorb the most-negative multiplicand), multiplier_reg, q_res, and count all 0.
  - Outputs: out 0, resp_id 0, resp_valid 0, busy 0, req_ready all 0.
- States are IDLE, RUN and DONE.
- IDLE:
  - req_ready is combinational. Pick the first requester with req_valid set, searching from rr pointer upward and wrapping.
  - Assert only that requester's req_ready bit in the same cycle.
  - At the clock edge:
    - capture in1 (held internally) and in2 into multiplier_reg;
    - clear accumulator and q_res;
    - set count to width;
    - latch resp_id;
    - set rr pointer to granted+1 mod NREQ;
    - go to RUN.
  - With no req_valid, remain in IDLE with all req_ready low.
- RUN: each cycle performs one step.
  - Select the operation on {multiplier_reg[0], q_res}: 01 adds in1 (sign-extended) to accumulator; 10 subtracts it; 00 and 11 leave it unchanged.
  - Then arithmetic right-shift {accumulator, multiplier_reg, q_res} by 1.
  - Decrement count.
  - After the step taken with count==1, go to DONE.
  - req_ready is all 0 in RUN.
- DONE:
  - resp_valid is 1 and out holds {accumulator[width-1:0], multiplier_reg} as the low 2*width bits of the signed product.
  - out and resp_id stay stable until resp_ready is sampled high; then go to IDLE and clear resp_valid.
  - req_ready is all 0 in DONE, so no new grant is given in the same cycle as the response handshake.
- Latency: grant at edge T puts resp_valid high from cycle T+width+1. Throughput is one product per width+2 cycles minimum.
- Arithmetic: full signed two's-complement. -2^(width-1) * -2^(width-1) = +2^(2*width-2) is exact with no overflow.
- resp_ready is ignored outside DONE. Changes on req_valid and req_in* are ignored outside IDLE.
- Reset asserted mid-RUN or mid-DONE aborts the operation; the product is lost and resp_valid drops immediately.
- Fairness: a requester holding req_valid is granted within NREQ grants.

Decomposition:
- Package booth_pkg:
  - state enum (IDLE, RUN, DONE);
  - Booth op encoding (NOP/ADD/SUB);
  - the 2-bit decode constants.
- Sub-module booth_step, purely combinational: one add/sub plus arithmetic shift on {accumulator, multiplier_reg, q_res}. It is instantiated once; the controller owns the registers, count, arbiter and handshakes.

Test Plan:
- Single request, requester 0: in1=3, in2=-5 (6'h3B) -> resp_valid exactly 7 cycles after grant, out=12'hFF1, resp_id=0.
- Extreme operands: in1=-32, in2=-32 -> out=12'h400. Separately, in1=-32, in2=31 -> out=12'hC20.
- Zero and identity: in1=0, in2=-17 -> out=0. Then in1=-1, in2=-1 -> out=12'h001.
- All four requesters valid continuously from reset -> grants in order 0,1,2,3,0. Exactly one req_ready bit is high per grant, and never outside IDLE.
- Backpressure: hold resp_ready=0 for 5 cycles in DONE -> out and resp_id remain stable and no req_ready is asserted. Raise resp_ready -> IDLE on the next edge and the next grant follows one cycle later.
- Reset mid-RUN (3 steps in) -> all outputs 0 immediately. After release, a new request in1=7, in2=6 -> out=12'h02A.
